// File: rtl/seq_comparator.sv
// Multi-cycle magnitude comparator: walks the captured operands MSB-first one
// CHUNK-bit slice per cycle and resolves on the first unequal slice.
module seq_comparator #(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       cmp,
  input  logic             is_signed,
  output logic             busy,
  output logic             done,
  output logic             dout,
  output logic             eq_flag,
  output logic             lt_flag,
  output logic             gt_flag
);

  localparam int NSLICE = WIDTH / CHUNK;
  localparam int IW     = (NSLICE > 1) ? $clog2(NSLICE) : 1;
  localparam logic [IW-1:0]    TOP_IDX  = IW'(NSLICE - 1);
  localparam logic [WIDTH-1:0] SIGN_BIT = {1'b1, {(WIDTH-1){1'b0}}} >> 0;

  typedef enum logic {IDLE, RUN} state_t;

  state_t                       state, state_nx;
  logic [WIDTH-1:0]             a_q, b_q;
  logic [2:0]                   cmp_q;
  logic [IW-1:0]                idx;
  logic [NSLICE-1:0][CHUNK-1:0] a_v, b_v;
  logic [CHUNK-1:0]             sa, sb;
  logic                         accept, resolve, sl_eq, sl_lt, sl_gt;
  logic                         fin_eq, fin_lt, fin_gt;

  assign a_v   = a_q;
  assign b_v   = b_q;
  assign sa    = a_v[idx];
  assign sb    = b_v[idx];
  assign sl_eq = (sa == sb);
  assign sl_lt = (sa < sb);
  assign sl_gt = (sa > sb);
  assign busy  = (state == RUN);

  // Equal on the final slice means the whole operand matched.
  assign fin_eq = sl_eq;
  assign fin_lt = sl_lt;
  assign fin_gt = sl_gt;

  function automatic logic op_eval(input logic [2:0] op, input logic e,
                                   input logic l, input logic g);
    case (op)
      3'b000:  op_eval = e;
      3'b001:  op_eval = ~l;
      3'b010:  op_eval = l;
      3'b011:  op_eval = ~e;
      3'b100:  op_eval = g;
      3'b101:  op_eval = ~g;
      3'b110:  op_eval = 1'b1;
      default: op_eval = 1'b0;
    endcase
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    accept   = 1'b0;
    resolve  = 1'b0;
    case (state)
      IDLE: if (start) begin
        accept   = 1'b1;
        state_nx = RUN;
      end
      RUN: if (!sl_eq || idx == '0) begin
        resolve  = 1'b1;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // Signed operands are stored in offset-binary so the walk is always unsigned.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q     <= '0;
      b_q     <= '0;
      cmp_q   <= '0;
      idx     <= TOP_IDX;
      done    <= 1'b0;
      dout    <= 1'b0;
      eq_flag <= 1'b0;
      lt_flag <= 1'b0;
      gt_flag <= 1'b0;
    end else begin
      done <= resolve;
      if (accept) begin
        a_q   <= a ^ (is_signed ? SIGN_BIT : '0);
        b_q   <= b ^ (is_signed ? SIGN_BIT : '0);
        cmp_q <= cmp;
        idx   <= TOP_IDX;
      end else if (state == RUN && !resolve) begin
        idx <= idx - 1'b1;
      end
      if (resolve) begin
        dout    <= op_eval(cmp_q, fin_eq, fin_lt, fin_gt);
        eq_flag <= fin_eq;
        lt_flag <= fin_lt;
        gt_flag <= fin_gt;
      end
    end
  end

endmodule

// File: tb/tb_seq_comparator.sv
// Directed bench for seq_comparator (WIDTH=16, CHUNK=4): latency, flags, ops,
// handshake and mid-compare reset against hand-computed values.
module tb_seq_comparator;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [15:0] a = '0, b = '0;
  logic [2:0]  cmp = '0;
  logic        is_signed = 1'b0;
  logic        busy, done, dout, eq_flag, lt_flag, gt_flag;
  int          checks = 0;
  int          errors = 0;

  seq_comparator #(.WIDTH(16), .CHUNK(4)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b), .cmp(cmp),
    .is_signed(is_signed), .busy(busy), .done(done), .dout(dout),
    .eq_flag(eq_flag), .lt_flag(lt_flag), .gt_flag(gt_flag)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Launch one compare and return the number of edges after the start edge
  // until done is seen (0 means it never came).
  task automatic go(input logic [15:0] ta, input logic [15:0] tb_, input logic [2:0] tc,
                    input logic ts, output int lat);
    @(negedge clk);
    a = ta; b = tb_; cmp = tc; is_signed = ts; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    lat = 0;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk);
      #1;
      if (done) begin
        lat = i;
        break;
      end
    end
  endtask

  logic [7:0] ops_exp;
  int lat;
  int seen_done;

  initial begin
    // 1: reset values
    #12;
    chk("rst_busy", busy, 0);
    chk("rst_outs", {done, dout, eq_flag, lt_flag, gt_flag}, 0);
    @(negedge clk) rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("idle_busy", busy, 0);
    chk("idle_outs", {done, dout, eq_flag, lt_flag, gt_flag}, 0);

    // 2: equal operands walk every slice
    go(16'h1234, 16'h1234, 3'b000, 1'b0, lat);
    chk("eq_lat", lat, 4);
    chk("eq_res", {dout, eq_flag, lt_flag, gt_flag}, 4'b1100);
    @(posedge clk) #1;
    chk("done_pulse", done, 0);

    // 3: early termination, unsigned then signed
    go(16'h8000, 16'h7FFF, 3'b100, 1'b0, lat);
    chk("u_lat", lat, 1);
    chk("u_res", {dout, eq_flag, lt_flag, gt_flag}, 4'b1001);
    go(16'h8000, 16'h7FFF, 3'b100, 1'b1, lat);
    chk("s_lat", lat, 1);
    chk("s_res", {dout, eq_flag, lt_flag, gt_flag}, 4'b0010);

    // 4: every op on 5 vs 9 (dout for ops 000..111 = 0,0,1,1,0,1,1,0)
    ops_exp = 8'b0110_1100;
    for (int op = 0; op < 8; op++) begin
      go(16'd5, 16'd9, op[2:0], 1'b0, lat);
      chk($sformatf("op%0d_dout", op), dout, ops_exp[op]);
      chk($sformatf("op%0d_flags", op), {eq_flag, lt_flag, gt_flag}, 3'b010);
      chk($sformatf("op%0d_lat", op), lat, 4);
    end

    // 5: start held high, operands change while busy, back-to-back accept
    @(negedge clk);
    a = 16'h1234; b = 16'h1235; cmp = 3'b010; is_signed = 1'b0; start = 1'b1;
    @(posedge clk);
    #1 a = 16'hFFFF; b = 16'h0000; cmp = 3'b111;
    chk("hs_busy", busy, 1);
    chk("hs_hold", {dout, eq_flag, lt_flag, gt_flag}, 4'b0010);
    lat = 0;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk);
      #1;
      if (done) begin lat = i; break; end
    end
    chk("hs_lat", lat, 4);
    chk("hs_res", {dout, eq_flag, lt_flag, gt_flag}, 4'b1010);
    chk("hs_done_idle", busy, 0);
    @(posedge clk);
    #1 start = 1'b0;
    chk("b2b_busy", busy, 1);
    @(posedge clk) #1;
    chk("b2b_done", done, 1);
    chk("b2b_res", {dout, eq_flag, lt_flag, gt_flag}, 4'b0001);

    // 6: reset two cycles into a full-length compare
    @(negedge clk);
    a = 16'hFFFF; b = 16'hFFFF; cmp = 3'b000; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("mid_rst_outs", {busy, done, dout, eq_flag, lt_flag, gt_flag}, 0);
    seen_done = 0;
    repeat (4) begin
      @(posedge clk) #1;
      if (done) seen_done++;
    end
    @(negedge clk) rst_n = 1'b1;
    repeat (3) begin
      @(posedge clk) #1;
      if (done) seen_done++;
    end
    chk("mid_rst_nodone", seen_done, 0);
    chk("mid_rst_idle", busy, 0);
    go(16'hFFFF, 16'hFFFF, 3'b000, 1'b0, lat);
    chk("post_rst_lat", lat, 4);
    chk("post_rst_res", {dout, eq_flag, lt_flag, gt_flag}, 4'b1100);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
